// File: rtl/attention_qkt_seq_pkg.sv
// Shared constants and enumerations for the Q/K projection and Q x K^T score sequencer.
package attention_pkg;

  localparam int N_TOK_DEF   = 4;
  localparam int D_MODEL_DEF = 4;
  localparam int MAC_LAT_DEF = 3;
  localparam int IDX_W_DEF   = 2;

  typedef enum logic [1:0] {
    OP_Q = 2'd0,
    OP_K = 2'd1,
    OP_S = 2'd2
  } op_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROJ_Q,
    ST_PROJ_K,
    ST_DRAIN_K,
    ST_SCORE,
    ST_DRAIN_S,
    ST_DONE
  } state_e;

endpackage

// File: rtl/attention_qkt_seq_idx_counter.sv
// Nested k/col/row index counter: k innermost, row outermost.
// The col limit is a runtime input so one counter serves both projection and score phases.
module attention_idx_counter #(
  parameter int IDX_W   = 2,
  parameter int K_LIM   = 3,
  parameter int ROW_LIM = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_advance,
  input  logic [IDX_W-1:0] i_col_lim,
  output logic [IDX_W-1:0] o_k,
  output logic [IDX_W-1:0] o_col,
  output logic [IDX_W-1:0] o_row,
  output logic             o_wrap
);

  localparam logic [IDX_W-1:0] L_K_LIM   = IDX_W'(K_LIM);
  localparam logic [IDX_W-1:0] L_ROW_LIM = IDX_W'(ROW_LIM);

  logic [IDX_W-1:0] r_k;
  logic [IDX_W-1:0] r_col;
  logic [IDX_W-1:0] r_row;
  logic             w_k_end;
  logic             w_col_end;
  logic             w_row_end;

  assign w_k_end   = (r_k == L_K_LIM);
  assign w_col_end = (r_col == i_col_lim);
  assign w_row_end = (r_row == L_ROW_LIM);

  // Clear wins over advance so a phase change always restarts at (0,0,0).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_k   <= '0;
      r_col <= '0;
      r_row <= '0;
    end else if (i_clear) begin
      r_k   <= '0;
      r_col <= '0;
      r_row <= '0;
    end else if (i_advance) begin
      r_k <= w_k_end ? '0 : r_k + IDX_W'(1);
      if (w_k_end) begin
        r_col <= w_col_end ? '0 : r_col + IDX_W'(1);
        if (w_col_end) begin
          r_row <= w_row_end ? '0 : r_row + IDX_W'(1);
        end
      end
    end
  end

  assign o_k    = r_k;
  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_wrap = w_k_end & w_col_end & w_row_end;

endmodule

// File: rtl/attention_qkt_seq.sv
// Sequencer issuing Q = I x WQ, K = I x WK, then S = Q x K^T products to a shared pipelined MAC.
// Drain states let the MAC pipeline empty before its results are consumed or reported done.
module attention_qkt_seq
  import attention_pkg::*;
#(
  parameter int N_TOK   = N_TOK_DEF,
  parameter int D_MODEL = D_MODEL_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_mac_ready,
  output logic             o_op_valid,
  output logic [1:0]       o_op_sel,
  output logic [IDX_W-1:0] o_op_row,
  output logic [IDX_W-1:0] o_op_col,
  output logic [IDX_W-1:0] o_op_k,
  output logic             o_op_first,
  output logic             o_op_last,
  output logic             o_busy,
  output logic             o_done
);

  localparam int DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DRAIN_W-1:0] L_DRAIN_LAST = DRAIN_W'(MAC_LAT - 1);
  localparam logic [IDX_W-1:0]   L_K_LAST     = IDX_W'(D_MODEL - 1);

  state_e             r_state;
  state_e             w_next;
  logic [DRAIN_W-1:0] r_drain;
  logic [DRAIN_W-1:0] w_drain_next;
  logic               w_valid;
  op_sel_e            w_sel;
  logic [IDX_W-1:0]   w_col_lim;
  logic               w_accept;
  logic               w_clear;
  logic               w_wrap;
  logic [IDX_W-1:0]   w_k;
  logic [IDX_W-1:0]   w_col;
  logic [IDX_W-1:0]   w_row;

  assign w_valid   = (r_state == ST_PROJ_Q) || (r_state == ST_PROJ_K) || (r_state == ST_SCORE);
  assign w_sel     = (r_state == ST_PROJ_K) ? OP_K : ((r_state == ST_SCORE) ? OP_S : OP_Q);
  assign w_col_lim = (r_state == ST_SCORE) ? IDX_W'(N_TOK - 1) : IDX_W'(D_MODEL - 1);
  assign w_accept  = w_valid & i_mac_ready;

  attention_idx_counter #(
    .IDX_W  (IDX_W),
    .K_LIM  (D_MODEL - 1),
    .ROW_LIM(N_TOK - 1)
  ) u_idx (
    .i_clk    (i_clk),
    .i_rst_n  (i_reset_n),
    .i_clear  (w_clear),
    .i_advance(w_accept),
    .i_col_lim(w_col_lim),
    .o_k      (w_k),
    .o_col    (w_col),
    .o_row    (w_row),
    .o_wrap   (w_wrap)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_drain <= '0;
    end else begin
      r_state <= w_next;
      r_drain <= w_drain_next;
    end
  end

  // Abort overrides every transition; in IDLE it is a no-op and also blocks a simultaneous start.
  always_comb begin
    w_next       = r_state;
    w_drain_next = '0;
    w_clear      = 1'b0;
    case (r_state)
      ST_IDLE:    if (i_start && !i_abort) w_next = ST_PROJ_Q;
      ST_PROJ_Q:  if (w_accept && w_wrap) begin w_next = ST_PROJ_K;  w_clear = 1'b1; end
      ST_PROJ_K:  if (w_accept && w_wrap) begin w_next = ST_DRAIN_K; w_clear = 1'b1; end
      ST_DRAIN_K: if (r_drain == L_DRAIN_LAST) w_next = ST_SCORE;
                  else w_drain_next = r_drain + DRAIN_W'(1);
      ST_SCORE:   if (w_accept && w_wrap) begin w_next = ST_DRAIN_S; w_clear = 1'b1; end
      ST_DRAIN_S: if (r_drain == L_DRAIN_LAST) w_next = ST_DONE;
                  else w_drain_next = r_drain + DRAIN_W'(1);
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
    if (i_abort && (r_state != ST_IDLE)) begin
      w_next       = ST_IDLE;
      w_drain_next = '0;
      w_clear      = 1'b1;
    end
  end

  assign o_op_valid = w_valid;
  assign o_op_sel   = w_sel;
  assign o_op_row   = w_row;
  assign o_op_col   = w_col;
  assign o_op_k     = w_k;
  assign o_op_first = w_valid && (w_k == '0);
  assign o_op_last  = w_valid && (w_k == L_K_LAST);
  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_attention_qkt_seq.sv
// Self-checking bench for attention_qkt_seq: nested-loop op-order model plus directed timing cases.
module tb_attention_qkt_seq;

  localparam int N        = 4;
  localparam int D        = 4;
  localparam int IW       = 2;
  localparam int NOPS     = 2 * N * D * D + N * N * D;
  localparam int DONE_CYC = 2 * N * D * D + N * N * D + 2 * 3 + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          ready = 1'b1;
  logic          opValid, opFirst, opLast, busy, done;
  logic [1:0]    opSel;
  logic [IW-1:0] opRow, opCol, opK;

  int errors = 0;
  int checks = 0;
  int cycleCnt = 0;
  int acceptCycle = 0;
  int readyMode = 0;
  int expSel[NOPS];
  int expRow[NOPS];
  int expCol[NOPS];
  int expK[NOPS];
  int expIdx = 0;
  int accCnt = 0;
  int firstCnt = 0;
  int lastCnt = 0;
  int doneCnt = 0;

  always #5 clk = ~clk;

  attention_qkt_seq dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_start    (start),
    .i_abort    (abort),
    .i_mac_ready(ready),
    .o_op_valid (opValid),
    .o_op_sel   (opSel),
    .o_op_row   (opRow),
    .o_op_col   (opCol),
    .o_op_k     (opK),
    .o_op_first (opFirst),
    .o_op_last  (opLast),
    .o_busy     (busy),
    .o_done     (done)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Expected op stream: Q then K projections over (row, col, k), then scores over (row, token, k).
  function automatic void buildModel();
    int n = 0;
    for (int ph = 0; ph < 3; ph++) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < ((ph == 2) ? N : D); c++) begin
          for (int k = 0; k < D; k++) begin
            expSel[n] = ph;
            expRow[n] = r;
            expCol[n] = c;
            expK[n]   = k;
            n++;
          end
        end
      end
    end
  endfunction

  task automatic resetModel();
    expIdx   = 0;
    accCnt   = 0;
    firstCnt = 0;
    lastCnt  = 0;
  endtask

  initial forever begin
    @(posedge clk);
    cycleCnt++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (readyMode == 0) ready = 1'b1;
    else if (readyMode == 1) ready = 1'($urandom_range(0, 1));
  end

  // Compare process: every presented op must be the next one of the model stream.
  always @(negedge clk) begin
    if (rst_n) begin
      if (opValid) begin
        if (expIdx >= NOPS) begin
          checkOutput("model_overrun", expIdx, NOPS - 1);
        end else begin
          checkOutput("op_sel", int'(opSel), expSel[expIdx]);
          checkOutput("op_row", int'(opRow), expRow[expIdx]);
          checkOutput("op_col", int'(opCol), expCol[expIdx]);
          checkOutput("op_k", int'(opK), expK[expIdx]);
          checkOutput("op_first", int'(opFirst), (expK[expIdx] == 0) ? 1 : 0);
          checkOutput("op_last", int'(opLast), (expK[expIdx] == D - 1) ? 1 : 0);
          if (ready) begin
            accCnt++;
            if (opFirst) firstCnt++;
            if (opLast) lastCnt++;
            expIdx++;
          end
        end
      end else begin
        checkOutput("idle_first", int'(opFirst), 0);
        checkOutput("idle_last", int'(opLast), 0);
        checkOutput("idle_sel", int'(opSel), 0);
      end
      if (done) begin
        doneCnt++;
        checkOutput("run_accepts", accCnt, NOPS);
        checkOutput("run_firsts", firstCnt, NOPS / D);
        checkOutput("run_lasts", lastCnt, NOPS / D);
        resetModel();
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, int'(opValid), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_sel"}, int'(opSel), 0);
    checkOutput({tag, "_idx"}, int'({opRow, opCol, opK}), 0);
    checkOutput({tag, "_firstlast"}, int'({opFirst, opLast}), 0);
  endtask

  task automatic applyStimulus();
    start = 1'b1;
    @(posedge clk);
    #1;
    acceptCycle = cycleCnt;
    start = 1'b0;
  endtask

  task automatic waitDone(input int bound, output int cyc);
    bit seen = 0;
    cyc = -1;
    for (int i = 0; i < bound && !seen; i++) begin
      if (done) begin
        cyc  = cycleCnt - acceptCycle + 1;
        seen = 1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic waitOp(input int s, input int r, input int c, input int k, output int cyc);
    bit seen = 0;
    cyc = -1;
    for (int i = 0; i < 1000 && !seen; i++) begin
      if (opValid && opSel == 2'(s) && opRow == IW'(r) && opCol == IW'(c) && opK == IW'(k)) begin
        cyc  = cycleCnt - acceptCycle + 1;
        seen = 1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    int cyc;
    int dc0;
    buildModel();

    // Reset state
    rst_n = 1'b0;
    #2;
    checkAllZero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full run with mac_ready held high
    readyMode = 0;
    applyStimulus();
    checkOutput("first_op_valid", int'(opValid), 1);
    checkOutput("first_op_busy", int'(busy), 1);
    checkOutput("first_op_first", int'(opFirst), 1);
    waitOp(2, 0, 0, 0, cyc);
    checkOutput("first_score_cycle", cyc, 132);
    waitDone(1000, cyc);
    checkOutput("done_cycle", cyc, DONE_CYC);
    @(posedge clk);
    #1;
    checkOutput("done_single_pulse", int'(done), 0);
    checkOutput("idle_after_done", int'(busy), 0);

    // Stall at Q op (1,2,3) for 5 cycles
    readyMode = 2;
    ready = 1'b1;
    applyStimulus();
    waitOp(0, 1, 2, 3, cyc);
    checkOutput("stall_op_cycle", cyc, 28);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_valid", int'(opValid), 1);
      checkOutput("stall_sel", int'(opSel), 0);
      checkOutput("stall_idx", int'({opRow, opCol, opK}), 6'b01_10_11);
      checkOutput("stall_last", int'(opLast), 1);
    end
    ready = 1'b1;
    readyMode = 0;
    waitDone(1000, cyc);
    checkOutput("stall_done_cycle", cyc, DONE_CYC + 5);
    @(posedge clk);
    #1;

    // Abort during SCORE at (2,0,1)
    applyStimulus();
    waitOp(2, 2, 0, 1, cyc);
    checkOutput("abort_point_found", cyc, 132 + 33);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    resetModel();
    checkOutput("abort_valid", int'(opValid), 0);
    checkOutput("abort_busy", int'(busy), 0);
    dc0 = doneCnt;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    checkOutput("abort_no_done", doneCnt, dc0);
    applyStimulus();
    waitDone(1000, cyc);
    checkOutput("after_abort_done_cycle", cyc, DONE_CYC);
    @(posedge clk);
    #1;

    // Start pulses in PROJ_K and in DONE are ignored
    dc0 = doneCnt;
    applyStimulus();
    waitOp(1, 0, 0, 0, cyc);
    checkOutput("projk_start_cycle", cyc, 65);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(1000, cyc);
    checkOutput("ignored_start_done_cycle", cyc, DONE_CYC);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("done_start_ignored", int'(busy), 0);
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    checkOutput("one_done_per_start", doneCnt - dc0, 1);

    // Asynchronous reset mid-PROJ_Q
    applyStimulus();
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    rst_n = 1'b1;
    resetModel();
    @(posedge clk);
    #1;
    applyStimulus();
    checkOutput("restart_valid", int'(opValid), 1);
    checkOutput("restart_sel", int'(opSel), 0);
    checkOutput("restart_idx", int'({opRow, opCol, opK}), 0);
    waitDone(1000, cyc);
    checkOutput("restart_done_cycle", cyc, DONE_CYC);
    @(posedge clk);
    #1;

    // Random mac_ready over three back-to-back runs
    readyMode = 1;
    dc0 = doneCnt;
    for (int run = 0; run < 3; run++) begin
      applyStimulus();
      waitDone(5000, cyc);
      checkOutput("rand_done_seen", (cyc >= DONE_CYC) ? 1 : 0, 1);
      @(posedge clk);
      #1;
    end
    checkOutput("rand_done_count", doneCnt - dc0, 3);
    readyMode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
